// File: rtl/axis_key_sequencer.sv
// Key pulse-train generator feeding the envelope keyer's key_flag input.
// A trigger rising edge starts a sequence built from the on/off/count config latched at that start.
module axis_key_sequencer #(
    parameter int CNTR_WIDTH  = 32,
    parameter int PULSE_WIDTH = 16
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [CNTR_WIDTH-1:0]  cfg_on,
    input  logic [CNTR_WIDTH-1:0]  cfg_off,
    input  logic [PULSE_WIDTH-1:0] cfg_count,
    input  logic                   trigger,
    input  logic                   stop,
    output logic                   key_flag,
    output logic                   busy,
    output logic [PULSE_WIDTH-1:0] pulse_cnt,
    output logic                   done
);
    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    localparam logic [CNTR_WIDTH-1:0]  TMR_ONE = CNTR_WIDTH'(1);
    localparam logic [PULSE_WIDTH-1:0] CNT_ONE = PULSE_WIDTH'(1);

    state_t                 state, state_n;
    logic [CNTR_WIDTH-1:0]  timer, timer_n;
    logic [CNTR_WIDTH-1:0]  sh_on, sh_off;
    logic [PULSE_WIDTH-1:0] sh_count;
    logic [PULSE_WIDTH-1:0] cnt_n, cnt_inc;
    logic                   key_n, busy_n, done_n, latch;
    logic                   trig_d, start;
    logic [CNTR_WIDTH-1:0]  off_reload;

    assign start   = trigger & ~trig_d;
    assign cnt_inc = pulse_cnt + CNT_ONE;
    // A zero off-time still gives a one-cycle gap so pulses never merge.
    assign off_reload = (sh_off == '0) ? '0 : sh_off - TMR_ONE;

    always_comb begin
        state_n = state;
        timer_n = timer;
        key_n   = key_flag;
        busy_n  = busy;
        cnt_n   = pulse_cnt;
        done_n  = 1'b0;
        latch   = 1'b0;
        case (state)
            IDLE: begin
                if (start && cfg_on != '0) begin
                    latch   = 1'b1;
                    cnt_n   = '0;
                    timer_n = cfg_on - TMR_ONE;
                    state_n = ON;
                    key_n   = 1'b1;
                    busy_n  = 1'b1;
                end
            end
            ON: begin
                if (timer == '0) begin
                    cnt_n = cnt_inc;
                    key_n = 1'b0;
                    if (stop || (sh_count != '0 && cnt_inc == sh_count)) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = OFF;
                        timer_n = off_reload;
                    end
                end else begin
                    timer_n = timer - TMR_ONE;
                end
            end
            OFF: begin
                if (stop) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else if (timer == '0) begin
                    timer_n = sh_on - TMR_ONE;
                    key_n   = 1'b1;
                    state_n = ON;
                end else begin
                    timer_n = timer - TMR_ONE;
                end
            end
            default: begin
                state_n = IDLE;
                key_n   = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= IDLE;
            timer     <= '0;
            key_flag  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pulse_cnt <= '0;
            trig_d    <= 1'b0;
            sh_on     <= '0;
            sh_off    <= '0;
            sh_count  <= '0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            key_flag  <= key_n;
            busy      <= busy_n;
            done      <= done_n;
            pulse_cnt <= cnt_n;
            trig_d    <= trigger;
            if (latch) begin
                sh_on    <= cfg_on;
                sh_off   <= cfg_off;
                sh_count <= cfg_count;
            end
        end
    end
endmodule

// File: tb/tb_axis_key_sequencer.sv
// Scoreboard bench for axis_key_sequencer: stimulus queues per-cycle expectations,
// a monitor pops and compares them just after each rising edge.
module tb_axis_key_sequencer;
    localparam int CW = 32;
    localparam int PW = 16;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [CW-1:0] cfg_on = '0, cfg_off = '0;
    logic [PW-1:0] cfg_count = '0;
    logic          trigger = 1'b0, stop = 1'b0;
    logic          key_flag, busy, done;
    logic [PW-1:0] pulse_cnt;

    typedef struct {
        logic          key;
        logic          busy;
        logic          done;
        logic [PW-1:0] cnt;
        string         tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    axis_key_sequencer #(.CNTR_WIDTH(CW), .PULSE_WIDTH(PW)) dut (
        .aclk(aclk), .areset(areset), .cfg_on(cfg_on), .cfg_off(cfg_off),
        .cfg_count(cfg_count), .trigger(trigger), .stop(stop),
        .key_flag(key_flag), .busy(busy), .pulse_cnt(pulse_cnt), .done(done)
    );

    always #5 aclk = ~aclk;

    // Monitor: outputs are presented every cycle, so one expectation per edge.
    always @(posedge aclk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (key_flag !== e.key || busy !== e.busy || done !== e.done || pulse_cnt !== e.cnt) begin
                failures++;
                $display("FAIL %s: got key=%b busy=%b done=%b cnt=%0d, want key=%b busy=%b done=%b cnt=%0d",
                         e.tag, key_flag, busy, done, pulse_cnt, e.key, e.busy, e.done, e.cnt);
            end
        end
    end

    // Vectors read left to right in time; cnt is one hex digit per cycle.
    task automatic run(input string name, input int n,
                       input logic [63:0] rs, input logic [63:0] tg, input logic [63:0] st,
                       input logic [63:0] k, input logic [63:0] b, input logic [63:0] d,
                       input logic [255:0] c);
        for (int i = 0; i < n; i++) begin
            int   idx;
            exp_t e;
            idx = n - 1 - i;
            @(negedge aclk);
            areset  = rs[idx];
            trigger = tg[idx];
            stop    = st[idx];
            e.key  = k[idx];
            e.busy = b[idx];
            e.done = d[idx];
            e.cnt  = PW'(c[4*idx +: 4]);
            e.tag  = $sformatf("%s[c%0d]", name, i);
            q.push_back(e);
        end
    endtask

    task automatic set_cfg(input int on, input int off, input int cnt);
        cfg_on    = CW'(on);
        cfg_off   = CW'(off);
        cfg_count = PW'(cnt);
    endtask

    initial begin
        int waited;
        run("reset", 3, 3'b111, 0, 0, 0, 0, 0, 0);

        set_cfg(4, 3, 1);
        run("single", 6, 0, 6'b110000, 0, 6'b111100, 6'b111100, 6'b000010, 24'h000011);

        // Retrigger at c4 and cfg rewrite after c3 must not disturb the running train.
        set_cfg(2, 0, 3);
        run("train_a", 4, 0, 4'b1000, 0, 4'b1101, 4'b1111, 4'b0000, 16'h0011);
        set_cfg(7, 9, 1);
        run("train_b", 6, 0, 6'b100000, 0, 6'b101100, 6'b111100, 6'b000010, 24'h122233);

        set_cfg(5, 5, 0);
        run("cont_stop", 27, 0, 27'b10000_00000_00000_00000_00000_00,
            27'b00000_00000_00000_00000_00111_11,
            27'b11111_00000_11111_00000_11111_00,
            27'b11111_11111_11111_11111_11111_00,
            27'b00000_00000_00000_00000_00000_10,
            108'h00000_1111111111_2222222222_33);

        set_cfg(2, 4, 0);
        run("stop_off", 6, 0, 6'b100000, 6'b000100, 6'b110000, 6'b111000, 6'b000100, 24'h001111);

        set_cfg(0, 4, 2);
        run("on_zero", 4, 0, 4'b1100, 0, 0, 0, 0, 16'h1111);

        set_cfg(2, 1, 0);
        run("reset_on", 6, 6'b000010, 6'b100000, 0, 6'b110100, 6'b111100, 0, 24'h001100);

        set_cfg(2, 1, 0);
        run("stop_start", 4, 0, 4'b1000, 4'b1111, 4'b1100, 4'b1100, 4'b0010, 16'h0011);

        waited = 0;
        while (q.size() > 0 && waited < 20) begin
            @(negedge aclk);
            waited++;
        end
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached, want completion");
        $fatal(1, "watchdog");
    end
endmodule
